// File: rtl/spram_arb2.sv
// spram_arb2: two-requester round-robin arbiter and sequencer for one spram
// Byte-masked writes run as a read-modify-write because the RAM has no byte enables.
module spram_arb2 #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [AWIDTH-1:0]   m0_addr,
  input  logic [DWIDTH-1:0]   m0_wdata,
  input  logic [DWIDTH/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DWIDTH-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [AWIDTH-1:0]   m1_addr,
  input  logic [DWIDTH-1:0]   m1_wdata,
  input  logic [DWIDTH/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DWIDTH-1:0]   m1_rdata,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic                ram_cen,
  output logic                ram_wen,
  output logic [DWIDTH-1:0]   ram_din,
  input  logic [DWIDTH-1:0]   ram_dout,
  output logic                busy
);
  localparam int SW = DWIDTH / 8;
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              sel;
  logic              s_we;
  logic [AWIDTH-1:0] s_addr;
  logic [DWIDTH-1:0] s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DWIDTH-1:0] merged;
  always_comb begin
    sel = (m0_req && m1_req) ? rr_q : m1_req;
    s_we = sel ? m1_we : m0_we;
    s_addr = sel ? m1_addr : m0_addr;
    s_wdata = sel ? m1_wdata : m0_wdata;
    s_wstrb = sel ? m1_wstrb : m0_wstrb;
    for (int i = 0; i < SW; i++)
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
    state_d = IDLE;
    rr_d = rr_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    ram_cen = 1'b1;
    ram_wen = 1'b1;
    ram_addr = s_addr;
    ram_din = s_wdata;
    busy = 1'b0;
    if (state_q == RMW_WR) begin
      busy = 1'b1;
      ram_cen = 1'b0;
      ram_wen = 1'b0;
      ram_addr = addr_q;
      ram_din = merged;
    end else if (m0_req || m1_req) begin
      m0_gnt = !sel;
      m1_gnt = sel;
      rr_d = !sel;
      if (!s_we) begin
        ram_cen = 1'b0;
        m0_rvalid_d = !sel;
        m1_rvalid_d = sel;
      end else if (&s_wstrb) begin
        ram_cen = 1'b0;
        ram_wen = 1'b0;
      end else if (|s_wstrb) begin
        ram_cen = 1'b0;
        addr_d = s_addr;
        wdata_d = s_wdata;
        wstrb_d = s_wstrb;
        state_d = RMW_WR;
      end
    end
    // outputs stay quiet for the whole reset pulse, not just after the next edge
    if (!rst_b) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      ram_cen = 1'b1;
      ram_wen = 1'b1;
      busy = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;
endmodule
